// File: rtl/asmd_mult_arbiter_if.sv
// Requester and multiplier-side bundle for asmd_mult_arbiter.
// slave = arbiter view, master = requester/multiplier environment view.
interface asmd_mult_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int word_length = 4
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*word_length-1:0] req_word0;
  logic [NUM_REQ*word_length-1:0] req_word1;
  logic [NUM_REQ-1:0]             grant;
  logic [NUM_REQ-1:0]             done;
  logic [2*word_length-1:0]       result;
  logic                           busy;
  logic                           err;
  logic                           mult_start;
  logic [word_length-1:0]         mult_word0;
  logic [word_length-1:0]         mult_word1;
  logic [2*word_length-1:0]       mult_product;
  logic                           mult_ready;

  modport slave (
    input  req, req_word0, req_word1, mult_product, mult_ready,
    output grant, done, result, busy, err, mult_start, mult_word0, mult_word1
  );
  modport master (
    output req, req_word0, req_word1, mult_product, mult_ready,
    input  grant, done, result, busy, err, mult_start, mult_word0, mult_word1
  );
endinterface

// File: rtl/asmd_mult_arbiter.sv
// Round-robin sharing of one asmd_multiplier among NUM_REQ requesters.
// Define MULT_ARB_TIMEOUT_EN to add the per-phase watchdog (err pulse + forced done).
module asmd_mult_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int word_length = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  asmd_mult_arbiter_if.slave    bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, REPORT} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]            ptr, own, win, own_inc;
  logic                     win_vld, take, fin, tout;
  logic [NUM_REQ-1:0]       grant, done;
  logic [2*word_length-1:0] result;
  logic [word_length-1:0]   w0_q, w1_q;
  logic                     start_c, busy_c;
  logic [word_length-1:0]   w0 [NUM_REQ];
  logic [word_length-1:0]   w1 [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w0[i] = bus.req_word0[i*word_length +: word_length];
    assign w1[i] = bus.req_word1[i*word_length +: word_length];
  end

  // First asserted req at or above ptr, wrapping around.
  always_comb begin
    int j;
    win     = '0;
    win_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_vld && bus.req[IW'(j)]) begin
        win_vld = 1'b1;
        win     = IW'(j);
      end
    end
  end

  assign own_inc = (own == IW'(NUM_REQ-1)) ? '0 : own + IW'(1);
  assign take    = (state == IDLE) && win_vld && bus.mult_ready;
  assign fin     = (state == WAIT_DONE) && bus.mult_ready;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1;
  logic [TW-1:0] tmr;
  logic          err_q;

  // tmr counts edges spent in the current phase without its exit condition.
  assign tout = ((state == START && bus.mult_ready) ||
                 (state == WAIT_DONE && !bus.mult_ready)) && (tmr == TW'(TIMEOUT-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= tout;
      if (take || (state == START && !bus.mult_ready)) tmr <= '0;
      else if (state == START || state == WAIT_DONE)   tmr <= tmr + TW'(1);
    end
  end
  assign bus.err = err_q;
`else
  assign tout    = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (take) state_nxt = START;
      START:     if (!bus.mult_ready) state_nxt = WAIT_DONE;
                 else if (tout)       state_nxt = REPORT;
      WAIT_DONE: if (fin || tout) state_nxt = REPORT;
      REPORT:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_c = (state == START);
    busy_c  = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant  <= '0;
      done   <= '0;
      result <= '0;
      w0_q   <= '0;
      w1_q   <= '0;
      own    <= '0;
      ptr    <= '0;
    end else begin
      done <= '0;
      if (take) begin
        grant      <= '0;
        grant[win] <= 1'b1;
        own        <= win;
        w0_q       <= w0[win];
        w1_q       <= w1[win];
      end
      // A finished or timed-out transaction both hand done back to the owner.
      if (fin || tout) begin
        result <= fin ? bus.mult_product : '0;
        done   <= grant;
        grant  <= '0;
        ptr    <= own_inc;
      end
    end
  end

  assign bus.grant      = grant;
  assign bus.done       = done;
  assign bus.result     = result;
  assign bus.busy       = busy_c;
  assign bus.mult_start = start_c;
  assign bus.mult_word0 = w0_q;
  assign bus.mult_word1 = w1_q;
endmodule

// File: tb/tb_asmd_mult_arbiter.sv
// Directed bench for asmd_mult_arbiter with a behavioural ready/start multiplier.
module tb_asmd_mult_arbiter;
  localparam int N   = 4;
  localparam int WL  = 4;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  asmd_mult_arbiter_if #(.NUM_REQ(N), .word_length(WL)) bus ();

  asmd_mult_arbiter #(.NUM_REQ(N), .word_length(WL), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Multiplier model: accepts start while ready, drops ready, returns a*b LAT+1 edges later.
  logic          force_rdy = 1'b0;
  logic [WL-1:0] ma, mb;
  int            mcnt = 0;
  initial begin
    bus.mult_ready   = 1'b1;
    bus.mult_product = '0;
  end
  always @(posedge clk) begin
    if (force_rdy) bus.mult_ready <= 1'b1;
    else if (bus.mult_ready && bus.mult_start) begin
      bus.mult_ready <= 1'b0;
      ma   <= bus.mult_word0;
      mb   <= bus.mult_word1;
      mcnt <= LAT;
    end else if (!bus.mult_ready) begin
      if (mcnt == 0) begin
        bus.mult_ready   <= 1'b1;
        bus.mult_product <= ma * mb;
      end else mcnt <= mcnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // grant/done must each be one-hot or zero and never both active.
  always @(negedge clk) begin
    if (!reset) begin
      n_chk++;
      if (!$onehot0(bus.grant) || !$onehot0(bus.done) || (|bus.grant && |bus.done)) begin
        n_fail++;
        $display("FAIL onehot: grant=%b done=%b", bus.grant, bus.done);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(output logic [N-1:0] d);
    d = '0;
    for (int c = 0; c < 100 && d == '0; c++) begin
      @(negedge clk);
      d = bus.done;
    end
    if (d == '0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: got no done, expected a pulse within 100 cycles");
    end
  endtask

  typedef struct {
    logic [N-1:0]         req;
    logic [N*WL-1:0]      w0, w1;
    int                   n;
    logic [N-1:0][1:0]    ord;
    logic [N-1:0][2*WL-1:0] res;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [N-1:0] d;
    int cyc;
    vecs[0] = '{req:4'b0001, w0:16'h0003, w1:16'h0002, n:1, ord:8'h00, res:{8'd0, 8'd0, 8'd0, 8'd6}};
    vecs[1] = '{req:4'b1111, w0:16'h7531, w1:16'h8642, n:4, ord:8'hE4, res:{8'd56, 8'd30, 8'd12, 8'd2}};
    vecs[2] = '{req:4'b0010, w0:16'h00F0, w1:16'h00F0, n:1, ord:8'h01, res:{8'd0, 8'd0, 8'd0, 8'd225}};
    vecs[3] = '{req:4'b1000, w0:16'h0000, w1:16'h9000, n:1, ord:8'h03, res:{8'd0, 8'd0, 8'd0, 8'd0}};
    vecs[4] = '{req:4'b1010, w0:16'h2050, w1:16'h3070, n:2, ord:8'h0D, res:{8'd0, 8'd0, 8'd6, 8'd35}};
    vecs[5] = '{req:4'b0101, w0:16'h0F01, w1:16'h0E0C, n:2, ord:8'h08, res:{8'd0, 8'd0, 8'd210, 8'd12}};

    bus.req = '0; bus.req_word0 = '0; bus.req_word1 = '0;
    repeat (2) @(negedge clk);
    chk("reset_grant", 32'(bus.grant), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_result", 32'(bus.result), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_start", 32'(bus.mult_start), 0);
    chk("reset_err", 32'(bus.err), 0);
    chk("reset_word0", 32'(bus.mult_word0), 0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) begin
      do_reset();
      bus.req_word0 = vecs[v].w0;
      bus.req_word1 = vecs[v].w1;
      bus.req       = vecs[v].req;
      for (int k = 0; k < vecs[v].n; k++) begin
        wait_done(d);
        chk($sformatf("v%0d_done%0d", v, k), 32'(d), 32'(4'b0001 << vecs[v].ord[k]));
        chk($sformatf("v%0d_res%0d", v, k), 32'(bus.result), 32'(vecs[v].res[k]));
        bus.req = bus.req & ~d;
      end
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", v), 32'(bus.busy), 0);
    end

    // Latency: grant/start one cycle after request, done LAT+4 cycles after request.
    do_reset();
    bus.req_word0 = 16'h0003; bus.req_word1 = 16'h0003;
    bus.req = 4'b0001;
    @(negedge clk);
    chk("lat_grant", 32'(bus.grant), 1);
    chk("lat_start", 32'(bus.mult_start), 1);
    chk("lat_busy", 32'(bus.busy), 1);
    cyc = 1;
    while (bus.done == '0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("lat_cycles", 32'(cyc), 32'(LAT + 4));
    chk("lat_result", 32'(bus.result), 9);
    bus.req = '0;

    // Fairness: req0 held, req2 joins after req0's first done -> 0,2,0.
    do_reset();
    bus.req_word0 = 16'h0402; bus.req_word1 = 16'h0503;
    bus.req = 4'b0001;
    wait_done(d);
    chk("rr_first", 32'(d), 32'b0001);
    chk("rr_first_res", 32'(bus.result), 6);
    bus.req = 4'b0101;
    wait_done(d);
    chk("rr_second", 32'(d), 32'b0100);
    chk("rr_second_res", 32'(bus.result), 20);
    bus.req = 4'b0001;
    wait_done(d);
    chk("rr_third", 32'(d), 32'b0001);
    bus.req = '0;
    @(negedge clk);

    // Operand change during WAIT_DONE does not disturb the product.
    bus.req_word0 = 16'h00F0; bus.req_word1 = 16'h00F0;
    bus.req = 4'b0010;
    repeat (3) @(negedge clk);
    chk("chg_waiting", 32'({bus.busy, bus.mult_start}), 32'b10);
    bus.req_word0 = 16'h0000;
    wait_done(d);
    chk("chg_done", 32'(d), 32'b0010);
    chk("chg_res", 32'(bus.result), 225);
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Asynchronous reset while in WAIT_DONE.
    bus.req_word0 = 16'h0003; bus.req_word1 = 16'h0003;
    bus.req = 4'b0001;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_grant", 32'(bus.grant), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    chk("arst_result", 32'(bus.result), 0);
    chk("arst_word0", 32'(bus.mult_word0), 0);
    bus.req = '0;
    @(negedge clk);
    reset = 1'b0;
    d = '0;
    repeat (8) begin
      @(negedge clk);
      d = d | bus.done;
    end
    chk("arst_no_done", 32'(d), 0);
    bus.req = 4'b0001;
    wait_done(d);
    chk("arst_redo", 32'(d), 32'b0001);
    chk("arst_redo_res", 32'(bus.result), 9);
    bus.req = '0;
    repeat (12) @(negedge clk);

    // Multiplier never drops ready.
    force_rdy = 1'b1;
    do_reset();
    bus.req = 4'b0001;
`ifdef MULT_ARB_TIMEOUT_EN
    cyc = 0;
    while (!bus.err && bus.done == '0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("tout_cycles", 32'(cyc), 9);
    chk("tout_err", 32'(bus.err), 1);
    chk("tout_done", 32'(bus.done), 32'b0001);
    chk("tout_result", 32'(bus.result), 0);
    bus.req = '0;
    @(negedge clk);
    chk("tout_err_pulse", 32'(bus.err), 0);
`else
    d = '0;
    cyc = 0;
    repeat (20) begin
      @(negedge clk);
      d = d | bus.done;
      cyc = cyc + int'(bus.err);
    end
    chk("hang_busy", 32'(bus.busy), 1);
    chk("hang_start", 32'(bus.mult_start), 1);
    chk("hang_err", 32'(cyc), 0);
    chk("hang_no_done", 32'(d), 0);
`endif
    bus.req = '0;
    force_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/asmd_mult_arbiter.md
# asmd_mult_arbiter

Round-robin arbiter and sequencer that shares one `asmd_multiplier` among `NUM_REQ` requesters. It sits between the requesters and the multiplier's `start`/`word0`/`word1`/`product`/`ready` ports. It latches the winning requester's operands and drives the multiplier's start handshake. It returns the product to that requester with a one-cycle `done` pulse.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `word_length`, 4, operand width; must match the multiplier instance
- `TIMEOUT`, 64, watchdog limit in cycles per handshake phase (used only with `MULT_ARB_TIMEOUT_EN`)

- `clk` in 1: the single clock; all logic on the rising edge
- `reset` in 1: asynchronous, active-high
- `req` in `NUM_REQ`: level request per requester, held until its `done`
- `req_word0` in `NUM_REQ*word_length`: flattened operand A; slice i = `[i*word_length +: word_length]`
- `req_word1` in `NUM_REQ*word_length`: flattened operand B, same packing
- `grant` out `NUM_REQ`: one-hot owner of the current transaction
- `done` out `NUM_REQ`: one-cycle completion pulse to the owner
- `result` out `2*word_length`: product, valid with `done`, held until the next `done`
- `busy` out 1: high in every state except IDLE
- `err` out 1: one-cycle timeout pulse; constant 0 without the macro
- `mult_start`, `mult_word0`, `mult_word1` out 1/`word_length`/`word_length`: to the multiplier
- `mult_product` in `2*word_length`, `mult_ready` in 1: from the multiplier

## Operation
- States: IDLE, START, WAIT_DONE, REPORT.
- **IDLE**
  - Arbitrate when `|req` and `mult_ready==1`.
  - Winner is the first asserted `req` searching upward, with wrap, from `ptr`.
  - `ptr` resets to 0.
  - The next edge registers `grant`, latches the winner's operands into `mult_word0`/`mult_word1`, and moves to START.
- **START**
  - `mult_start=1` and operands are stable.
  - Move to WAIT_DONE on the first edge with `mult_ready==0`, which means the multiplier has accepted.
- **WAIT_DONE**
  - `mult_start=0`.
  - On the first edge with `mult_ready==1`: capture `mult_product` into `result`, pulse `done[g]`, clear `grant`, set `ptr=(g+1)%NUM_REQ`, and move to REPORT.
- **REPORT**
  - One cycle; `req` is ignored.
  - Unconditionally return to IDLE.
  - A `req` still high in IDLE is a new request.
- Operand capture is at grant. Later changes on `req_word*` or `req` do not affect the running transaction.
- Dropping `req` mid-transaction does not abort it; `done` still pulses.
- Product is passed through unmodified, full `2*word_length` bits, unsigned.
- Reset values: `grant=0`, `done=0`, `result=0`, `busy=0`, `err=0`, `mult_start=0`, `mult_word0=0`, `mult_word1=0`, state=IDLE, `ptr=0`.
- Reset mid-transaction returns to IDLE with all of the above. No `done` is issued; the requester must re-request.

## Timing
- `req` high with IDLE and `mult_ready` high at edge k:
  - `grant` and `mult_start` high from k+1.
  - `busy` high from k+1.
- `mult_start` stays high at least one cycle, until `mult_ready` falls.
- `done`/`result` update on the edge that samples `mult_ready` rising. Pulse lasts exactly one cycle; `grant` falls on that same edge.
- Back-to-back: the next `grant` occurs no earlier than 2 cycles after the previous `done` (REPORT then IDLE arbitration).
- Minimum requester-visible latency is multiplier latency + 3 cycles.
- `done` and `grant` are always one-hot or zero, never set for different indices simultaneously.

## Configuration
- `MULT_ARB_TIMEOUT_EN` defined:
  - A counter reloads on entry to START and to WAIT_DONE.
  - If it reaches `TIMEOUT` before the exit condition, the block pulses `err` and `done[g]` together, sets `result=0`, advances `ptr`, and goes to REPORT.
- Undefined: no counter. START and WAIT_DONE wait indefinitely, and `err` is tied 0.

## Test plan
- Single request: `req=4'b0001`, operands 3,2 → `grant=0001`, one `done=0001` pulse, `result=8'd6`, `busy` back to 0 after REPORT.
- All four requesting at once with (1,2),(3,4),(5,6),(7,8) → `done` order 0,1,2,3; results 2,12,30,56; `grant` never multi-hot.
- Round-robin fairness: req0 held continuously and req2 asserted after req0's first `done` → service order 0,2,0; req0 never wins twice in a row while req2 waits.
- Extremes and operand change: 15×15 → `result=8'd225`; requester changes `req_word0` to 0 during WAIT_DONE → still 225. Then 0×9 → 0.
- Reset mid-transaction: assert `reset` during WAIT_DONE → all outputs 0 immediately (asynchronous), no `done`. A re-request after release completes normally.
- Timeout (macro on, `TIMEOUT=8`): hold `mult_ready=1` permanently → after 8 cycles in START, `err` and `done[g]` pulse together with `result=0`. Macro off: the same stimulus leaves the block hung in START with `err=0`.
